// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the pipelined 64-bit ALU and its command issuer.
`timescale 1ns/1ps
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_IDLE = 4'hF;

    // Only ADD and SUB update the ALU carry flag; every other opcode leaves a stale value behind.
    function automatic logic is_carry_op(input logic [3:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with wrap-bit pointers and an occupancy count.
`timescale 1ns/1ps
module alu_rsp_fifo #(
    parameter int DATA_W = 67,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q;
    logic [PW-1:0]     rdPtr_q;
    logic              full;
    logic              wrOk;
    logic              rdOk;

    assign count_o   = wrPtr_q - rdPtr_q;
    assign empty_o   = (count_o == '0);
    assign full      = (count_o == PW'(DEPTH));
    assign wrOk      = wr_en_i && (!full || rd_en_i);
    assign rdOk      = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rdPtr_q[AW-1:0]];

    // Storage and pointers; a pop at full frees the slot the same-cycle write lands in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wrOk) begin
                mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (rdOk) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues tagged commands into the fixed-latency ALU, tracks them through its pipeline and
// queues results for downstream; credits keep the non-stallable pipe from overrunning the FIFO.
`timescale 1ns/1ps
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int ALU_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_opcode_i,
    input  logic [WIDTH-1:0]  cmd_a_i,
    input  logic [WIDTH-1:0]  cmd_b_i,
    input  logic [4:0]        cmd_shift_i,
    input  logic [TAG_W-1:0]  cmd_tag_i,
    output logic [3:0]        alu_opcode_o,
    output logic [WIDTH-1:0]  alu_input1_o,
    output logic [WIDTH-1:0]  alu_input2_o,
    output logic [4:0]        alu_shift_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_carry_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_result_o,
    output logic              rsp_carry_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              busy_o
);

    localparam int STAGES = ALU_LAT + 1;
    localparam int FCW    = $clog2(DEPTH) + 1;
    localparam int CRW    = $clog2(DEPTH + STAGES + 1);
    localparam int RSP_W  = WIDTH + 1 + TAG_W;

    typedef struct packed {
        logic             valid;
        logic [3:0]       opcode;
        logic [TAG_W-1:0] tag;
    } trackEntry_t;

    trackEntry_t        track_q [STAGES];
    logic [CRW-1:0]     inflight_q;
    logic [CRW-1:0]     inflight_d;
    logic               readyEn_q;
    logic [FCW-1:0]     fifoCount;
    logic               fifoEmpty;
    logic               issue;
    logic               fifoWrite;
    logic               fifoRead;
    logic               carryMasked;
    logic [RSP_W-1:0]   wrData;
    logic [RSP_W-1:0]   rdData;

    assign cmd_ready_o = readyEn_q && ((inflight_q + CRW'(fifoCount)) < CRW'(DEPTH));
    assign issue       = cmd_valid_i && cmd_ready_o;
    assign fifoWrite   = track_q[STAGES-1].valid;
    assign fifoRead    = rsp_valid_o && rsp_ready_i;
    assign carryMasked = alu_carry_i && is_carry_op(track_q[STAGES-1].opcode);
    assign wrData      = {alu_result_i, carryMasked, track_q[STAGES-1].tag};

    assign rsp_valid_o = !fifoEmpty;
    assign {rsp_result_o, rsp_carry_o, rsp_tag_o} = rdData;
    assign busy_o      = (inflight_q != '0) || (fifoCount != '0);

    // Holds cmd_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    // ALU input registers: load on issue, otherwise park the ALU on the idle opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode_o <= '0;
            alu_input1_o <= '0;
            alu_input2_o <= '0;
            alu_shift_o  <= '0;
        end else if (issue) begin
            alu_opcode_o <= cmd_opcode_i;
            alu_input1_o <= cmd_a_i;
            alu_input2_o <= cmd_b_i;
            alu_shift_o  <= cmd_shift_i;
        end else begin
            alu_opcode_o <= OP_IDLE;
            alu_input1_o <= '0;
            alu_input2_o <= '0;
            alu_shift_o  <= '0;
        end
    end

    // Track pipe shadows the ALU so the last stage lines up with a stable result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                track_q[i] <= '0;
            end
        end else begin
            track_q[0] <= '{valid: issue, opcode: cmd_opcode_i, tag: cmd_tag_i};
            for (int i = 1; i < STAGES; i++) begin
                track_q[i] <= track_q[i-1];
            end
        end
    end

    // In-flight count rises on issue and falls when the entry lands in the FIFO.
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !fifoWrite) begin
            inflight_d = inflight_q + CRW'(1);
        end else if (!issue && fifoWrite) begin
            inflight_d = inflight_q - CRW'(1);
        end
    end

    // In-flight counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    alu_rsp_fifo #(
        .DATA_W (RSP_W),
        .DEPTH  (DEPTH)
    ) rspFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifoWrite),
        .wr_data_i (wrData),
        .rd_en_i   (fifoRead),
        .rd_data_o (rdData),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount)
    );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer, driving a behavioural stand-in of the pipelined ALU as responder.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode = '0;
    logic [WIDTH-1:0]  cmd_a = '0;
    logic [WIDTH-1:0]  cmd_b = '0;
    logic [4:0]        cmd_shift = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic [3:0]        alu_opcode;
    logic [WIDTH-1:0]  alu_input1;
    logic [WIDTH-1:0]  alu_input2;
    logic [4:0]        alu_shift;
    logic [WIDTH-1:0]  aluResult;
    logic              aluCarry;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_carry;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;

    int vectorCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(
        .WIDTH   (WIDTH),
        .ALU_LAT (2),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_shift_i  (cmd_shift),
        .cmd_tag_i    (cmd_tag),
        .alu_opcode_o (alu_opcode),
        .alu_input1_o (alu_input1),
        .alu_input2_o (alu_input2),
        .alu_shift_o  (alu_shift),
        .alu_result_i (aluResult),
        .alu_carry_i  (aluCarry),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_carry_o  (rsp_carry),
        .rsp_tag_o    (rsp_tag),
        .busy_o       (busy)
    );

    // ALU stand-in: inputs sampled into a stage register, result/carry registered one edge later.
    logic              aluRst;
    logic [WIDTH-1:0]  aluCalcRes;
    logic              aluCalcCarry;
    logic [WIDTH-1:0]  aluStageRes;
    logic              aluStageCarry;
    logic              aluStageCarryOp;

    assign aluRst = ~rst_n;

    always_comb begin
        aluCalcRes = '0;
        aluCalcCarry = 1'b0;
        case (alu_opcode)
            OP_ADD:  {aluCalcCarry, aluCalcRes} = {1'b0, alu_input1} + {1'b0, alu_input2};
            OP_SUB:  begin
                aluCalcRes = alu_input1 - alu_input2;
                aluCalcCarry = (alu_input1 < alu_input2);
            end
            OP_MUL:  aluCalcRes = alu_input1 * alu_input2;
            OP_NAND: aluCalcRes = ~(alu_input1 & alu_input2);
            default: aluCalcRes = '0;
        endcase
    end

    always @(posedge clk or posedge aluRst) begin
        if (aluRst) begin
            aluStageRes <= '0;
            aluStageCarry <= 1'b0;
            aluStageCarryOp <= 1'b0;
            aluResult <= '0;
            aluCarry <= 1'b0;
        end else begin
            aluStageRes <= aluCalcRes;
            aluStageCarry <= aluCalcCarry;
            aluStageCarryOp <= (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);
            aluResult <= aluStageRes;
            if (aluStageCarryOp) aluCarry <= aluStageCarry;
        end
    end

    // Monitor: samples just before each rising edge and records handshakes.
    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic [TAG_W-1:0] tag;
        int               cycle;
    } pop_t;

    pop_t popQ[$];
    int cycle = 0;
    int lastIssueCycle = 0;
    int acceptCount = 0;
    int outstanding = 0;
    int maxOutstanding = 0;

    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acceptCount++;
                lastIssueCycle = cycle;
                outstanding++;
            end
            if (rsp_valid && rsp_ready) begin
                popQ.push_back('{result: rsp_result, carry: rsp_carry, tag: rsp_tag, cycle: cycle});
                outstanding--;
            end
            if (outstanding > maxOutstanding) maxOutstanding = outstanding;
        end
        cycle++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] shift, input logic [TAG_W-1:0] tag);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_opcode = op;
        cmd_a = a;
        cmd_b = b;
        cmd_shift = shift;
        cmd_tag = tag;
        #4;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            #4;
            guard++;
        end
        if (guard >= 50) checkOutput("issue_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitPops(input int target);
        int guard = 0;
        while (popQ.size() < target && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (popQ.size() < target) checkOutput("rsp_timeout", 64'(popQ.size()), 64'(target));
    endtask

    typedef struct {
        logic [3:0]       op;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [4:0]       shift;
        logic [TAG_W-1:0] tag;
        logic [63:0]      expResult;
        logic             expCarry;
    } vec_t;

    vec_t vecs[7];

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int acc0;
        int k;

        vecs[0] = '{OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0,  2'd2, 64'd0, 1'b1};
        vecs[1] = '{OP_SUB,  64'd3, 64'd5, 5'd3,  2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[2] = '{OP_MUL,  64'd6, 64'd7, 5'd17, 2'd3, 64'd42, 1'b0};
        vecs[3] = '{OP_NAND, 64'hF0, 64'hF0, 5'd31, 2'd0, 64'hFFFF_FFFF_FFFF_FF0F, 1'b0};
        vecs[4] = '{4'd9,    64'd5, 64'd5, 5'd1,  2'd2, 64'd0, 1'b0};
        vecs[5] = '{OP_ADD,  64'd1, 64'd2, 5'd0,  2'd0, 64'd3, 1'b0};
        vecs[6] = '{OP_SUB,  64'd5, 64'd3, 5'd8,  2'd1, 64'd2, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        checkOutput("rst_rsp_result", rsp_result, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("post_rst_alu_idle", 64'(alu_opcode), 64'hF);

        // Single-command vectors
        for (int i = 0; i < 7; i++) begin
            base = popQ.size();
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shift, vecs[i].tag);
            checkOutput("alu_opcode", 64'(alu_opcode), 64'(vecs[i].op));
            checkOutput("alu_input1", alu_input1, vecs[i].a);
            checkOutput("alu_shift", 64'(alu_shift), 64'(vecs[i].shift));
            waitPops(base + 1);
            if (popQ.size() > base) begin
                checkOutput("vec_result", popQ[base].result, vecs[i].expResult);
                checkOutput("vec_carry", 64'(popQ[base].carry), 64'(vecs[i].expCarry));
                checkOutput("vec_tag", 64'(popQ[base].tag), 64'(vecs[i].tag));
                checkOutput("vec_pop_latency", 64'(popQ[base].cycle - lastIssueCycle), 64'd4);
            end
        end
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Back-to-back ADD/SUB/MUL/NAND
        base = popQ.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_shift = '0;
            cmd_tag = TAG_W'(i);
            case (i)
                0: begin cmd_opcode = OP_ADD;  cmd_a = 64'd10;  cmd_b = 64'd20;  end
                1: begin cmd_opcode = OP_SUB;  cmd_a = 64'd1;   cmd_b = 64'd2;   end
                2: begin cmd_opcode = OP_MUL;  cmd_a = 64'd6;   cmd_b = 64'd7;   end
                default: begin cmd_opcode = OP_NAND; cmd_a = 64'hF0; cmd_b = 64'hF0; end
            endcase
            #4;
            checkOutput("b2b_ready", 64'(cmd_ready), 64'd1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        waitPops(base + 4);
        if (popQ.size() >= base + 4) begin
            checkOutput("b2b_res0", popQ[base].result, 64'd30);
            checkOutput("b2b_res1", popQ[base+1].result, 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("b2b_carry1", 64'(popQ[base+1].carry), 64'd1);
            checkOutput("b2b_res2", popQ[base+2].result, 64'd42);
            checkOutput("b2b_carry2", 64'(popQ[base+2].carry), 64'd0);
            checkOutput("b2b_res3", popQ[base+3].result, 64'hFFFF_FFFF_FFFF_FF0F);
            for (int i = 0; i < 4; i++) begin
                checkOutput("b2b_tag", 64'(popQ[base+i].tag), 64'(i));
                checkOutput("b2b_consecutive", 64'(popQ[base+i].cycle - popQ[base].cycle), 64'(i));
            end
        end

        // Backpressure: credits stop issue at DEPTH
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        base = popQ.size();
        acc0 = acceptCount;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_opcode = OP_ADD;
            cmd_a = 64'(k);
            cmd_b = 64'd100;
            cmd_tag = TAG_W'(k);
            #4;
            if (cmd_ready) k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp_accepted", 64'(acceptCount - acc0), 64'd4);
        checkOutput("bp_ready_low", 64'(cmd_ready), 64'd0);
        checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("bp_hold_result", rsp_result, 64'd100);
        checkOutput("bp_hold_tag", 64'(rsp_tag), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #4;
        checkOutput("bp_ready_at_pop", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        #4;
        checkOutput("bp_ready_after_pop", 64'(cmd_ready), 64'd1);
        waitPops(base + 4);
        if (popQ.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("bp_result", popQ[base+i].result, 64'(i + 100));
                checkOutput("bp_tag", 64'(popQ[base+i].tag), 64'(i));
            end
        end

        // Reset with two in flight and one queued
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_opcode = OP_ADD;
            cmd_a = 64'(i);
            cmd_b = 64'd1;
            cmd_tag = TAG_W'(i);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_queued", 64'(rsp_valid), 64'd1);
        checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
        base = popQ.size();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_no_ghost_rsp", 64'(popQ.size() - base), 64'd0);
        checkOutput("rst_after_busy", 64'(busy), 64'd0);
        applyStimulus(OP_ADD, 64'd1, 64'd1, 5'd0, 2'd3);
        waitPops(base + 1);
        if (popQ.size() > base) begin
            checkOutput("rst_after_result", popQ[base].result, 64'd2);
            checkOutput("rst_after_carry", 64'(popQ[base].carry), 64'd0);
            checkOutput("rst_after_tag", 64'(popQ[base].tag), 64'd3);
        end

        checkOutput("credit_bound", 64'(maxOutstanding <= DEPTH), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
